// File: rtl/mont_exp_driver.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery multiplier.
// Define MONT_EXP_LZ_SKIP_EN to compile in the leading-zero SCAN state.
module mont_exp_driver #(
    parameter int DATA_W = 512,
    parameter int EXP_W  = 512,
    parameter int CNT_W  = $clog2(EXP_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_x,
    input  logic [EXP_W-1:0]  in_e,
    input  logic [DATA_W-1:0] in_m,
    input  logic [DATA_W-1:0] in_one,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              mul_resetn,
    output logic              mul_start,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    output logic [DATA_W-1:0] mul_m,
    input  logic [DATA_W-1:0] mul_result,
    input  logic              mul_done
);

    typedef enum logic [3:0] {
        IDLE,
`ifdef MONT_EXP_LZ_SKIP_EN
        SCAN,
`endif
        SQ_RST,
        SQ_START,
        SQ_WAIT,
        MUL_RST,
        MUL_START,
        MUL_WAIT,
        NEXT,
        DONE
    } state_t;

    state_t state, stateD;

    logic [DATA_W-1:0] acc, x_q, m_q;
    logic [EXP_W-1:0]  e_q;
    logic [CNT_W-1:0]  idx;
    logic              op_is_mul;

    logic capture, accFromMul, accFromX, idxDec, setMul, setSq;
    logic curBit, idxZero;

    assign curBit  = e_q[idx];
    assign idxZero = (idx == '0);

    always_comb begin
        stateD     = state;
        capture    = 1'b0;
        accFromMul = 1'b0;
        accFromX   = 1'b0;
        idxDec     = 1'b0;
        setMul     = 1'b0;
        setSq      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    capture = 1'b1;
                    setSq   = 1'b1;
`ifdef MONT_EXP_LZ_SKIP_EN
                    stateD  = SCAN;
`else
                    stateD  = SQ_RST;
`endif
                end
            end
`ifdef MONT_EXP_LZ_SKIP_EN
            SCAN: begin
                // first set bit: acc = in_one * x needs no multiplier op
                if (curBit) begin
                    accFromX = 1'b1;
                    stateD   = NEXT;
                end else if (idxZero) begin
                    stateD = DONE;
                end else begin
                    idxDec = 1'b1;
                end
            end
`endif
            SQ_RST:   stateD = SQ_START;
            SQ_START: stateD = SQ_WAIT;
            SQ_WAIT: begin
                if (mul_done) begin
                    accFromMul = 1'b1;
                    if (curBit) begin
                        setMul = 1'b1;
                        stateD = MUL_RST;
                    end else begin
                        stateD = NEXT;
                    end
                end
            end
            MUL_RST:   stateD = MUL_START;
            MUL_START: stateD = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_done) begin
                    accFromMul = 1'b1;
                    stateD     = NEXT;
                end
            end
            NEXT: begin
                if (idxZero) begin
                    stateD = DONE;
                end else begin
                    idxDec = 1'b1;
                    setSq  = 1'b1;
                    stateD = SQ_RST;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            x_q       <= '0;
            m_q       <= '0;
            e_q       <= '0;
            idx       <= '0;
            op_is_mul <= 1'b0;
        end else begin
            state <= stateD;
            if (capture) begin
                x_q <= in_x;
                e_q <= in_e;
                m_q <= in_m;
                acc <= in_one;
                idx <= CNT_W'(EXP_W - 1);
            end else begin
                if (accFromMul) acc <= mul_result;
                if (accFromX)   acc <= x_q;
                if (idxDec)     idx <= idx - 1'b1;
            end
            if (setMul) op_is_mul <= 1'b1;
            if (setSq)  op_is_mul <= 1'b0;
        end
    end

    assign result     = acc;
    assign done       = (state == DONE);
    assign mul_start  = (state == SQ_START) || (state == MUL_START);
    assign mul_resetn = !reset && !((state == IDLE) ||
                                    (state == SQ_RST) ||
                                    (state == MUL_RST));
    assign mul_a      = acc;
    assign mul_b      = op_is_mul ? x_q : acc;
    assign mul_m      = m_q;

endmodule
